// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with its own pointers, registered occupancy count,
// threshold flags, registered read data and sticky overflow/underflow flags.
module sync_fifo_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SIZE:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE + 1)'(AF_LEVEL);
  localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE + 1)'(AE_LEVEL);
  localparam logic [ADDR_SIZE:0] ONE     = (ADDR_SIZE + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_SIZE:0]    wr_ptr_reg;
  logic [ADDR_SIZE:0]    rd_ptr_reg;
  logic [ADDR_SIZE:0]    count_reg;
  logic [ADDR_SIZE:0]    count_next;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rd_valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  wr_acc;
  logic                  rd_acc;

  // A write into a full FIFO is allowed only when a read frees a slot the same edge.
  always_comb begin
    rd_acc = rd_en & ~empty;
    wr_acc = wr_en & (~full | rd_acc);
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + ONE;
      2'b01:   count_next = count_reg - ONE;
      default: count_next = count_reg;
    endcase
  end

  // Storage array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr_reg[ADDR_SIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rdata_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + ONE;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + ONE;
        rdata_reg  <= mem[rd_ptr_reg[ADDR_SIZE-1:0]];
      end
      rd_valid_reg <= rd_acc;
      count_reg    <= count_next;
      if (wr_en && !wr_acc) begin
        overflow_reg <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign rdata        = rdata_reg;
  assign rd_valid     = rd_valid_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Directed bench for sync_fifo_buf: depth-8 instance for data-path checks,
// depth-4 instance with tightened thresholds for the almost_* flags.
module tb_sync_fifo_buf;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  logic       clr2;
  logic       wr_en2;
  logic [7:0] wdata2;
  logic       rd_en2;
  logic [7:0] rdata2;
  logic       rd_valid2;
  logic       full2;
  logic       empty2;
  logic       almost_full2;
  logic       almost_empty2;
  logic [2:0] count2;
  logic       overflow2;
  logic       underflow2;

  int n_checks;
  int n_pass;

  sync_fifo_buf #(.DATA_WIDTH(8), .ADDR_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_buf #(.DATA_WIDTH(8), .ADDR_SIZE(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .wr_en(wr_en2), .wdata(wdata2), .rd_en(rd_en2),
    .rdata(rdata2), .rd_valid(rd_valid2), .full(full2), .empty(empty2),
    .almost_full(almost_full2), .almost_empty(almost_empty2), .count(count2),
    .overflow(overflow2), .underflow(underflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill8(input int base_mul);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wdata = 8'((i + 1) * base_mul);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #10;
    n_checks++;
    if (rdata !== 8'h00 || rd_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_regs got rdata=%h rd_valid=%b count=%0d ovf=%b unf=%b required 00 0 0 0 0",
               rdata, rd_valid, count, overflow, underflow);
    else n_pass++;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0)
      $display("FAIL reset_flags got empty=%b full=%b ae=%b af=%b required 1 0 1 0",
               empty, full, almost_empty, almost_full);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wdata = 8'((i + 1) * 17);
      tick();
      n_checks++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6) || full !== (i + 1 == 8))
        $display("FAIL fill_%0d got count=%0d af=%b full=%b required %0d %b %b",
                 i, count, almost_full, full, i + 1, (i + 1 >= 6), (i + 1 == 8));
      else n_pass++;
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (rdata !== 8'((i + 1) * 17) || rd_valid !== 1'b1)
        $display("FAIL drain_%0d got rdata=%h rd_valid=%b required %h 1",
                 i, rdata, rd_valid, 8'((i + 1) * 17));
      else n_pass++;
    end
    rd_en = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || count !== 4'd0)
      $display("FAIL drain_empty got empty=%b count=%0d required 1 0", empty, count);
    else n_pass++;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rdata !== 8'h88 || underflow !== 1'b0)
      $display("FAIL drain_hold got rd_valid=%b rdata=%h unf=%b required 0 88 0", rd_valid, rdata, underflow);
    else n_pass++;
  endtask

  task automatic test_overflow();
    fill8(17);
    wr_en = 1'b1;
    wdata = 8'hAA;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1)
      $display("FAIL ovf_set got ovf=%b count=%0d full=%b required 1 8 1", overflow, count, full);
    else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rdata !== 8'h11 || count !== 4'd7)
      $display("FAIL ovf_read got rdata=%h count=%0d required 11 7", rdata, count);
    else n_pass++;
    clr = 1'b1;
    wr_en = 1'b1;
    wdata = 8'hEE;
    tick();
    clr = 1'b0;
    wr_en = 1'b0;
    n_checks++;
    if (count !== 4'd0 || overflow !== 1'b0 || empty !== 1'b1 || rd_valid !== 1'b0 || rdata !== 8'h11)
      $display("FAIL ovf_clr got count=%0d ovf=%b empty=%b rd_valid=%b rdata=%h required 0 0 1 0 11",
               count, overflow, empty, rd_valid, rdata);
    else n_pass++;
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    wr_en = 1'b1;
    wdata = 8'h5A;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (underflow !== 1'b1 || count !== 4'd1 || rd_valid !== 1'b0)
      $display("FAIL unf_set got unf=%b count=%0d rd_valid=%b required 1 1 0", underflow, count, rd_valid);
    else n_pass++;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rdata !== 8'h5A || rd_valid !== 1'b1 || count !== 4'd0)
      $display("FAIL unf_read got rdata=%h rd_valid=%b count=%0d required 5a 1 0", rdata, rd_valid, count);
    else n_pass++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (underflow !== 1'b0)
      $display("FAIL unf_clr got unf=%b required 0", underflow);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] exp_b;
    fill8(1);
    for (int i = 0; i < 8; i++) q.push_back(8'(i + 1));
    for (int k = 0; k < 21; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wdata = (k == 0) ? 8'hC3 : 8'(8'h20 + k);
      q.push_back(wdata);
      exp_b = q.pop_front();
      tick();
      n_checks++;
      if (rdata !== exp_b || count !== 4'd8 || full !== 1'b1 || rd_valid !== 1'b1)
        $display("FAIL b2b_full_%0d got rdata=%h count=%0d full=%b rd_valid=%b required %h 8 1 1",
                 k, rdata, count, full, rd_valid, exp_b);
      else n_pass++;
    end
    wr_en = 1'b0;
    n_checks++;
    if (overflow !== 1'b0)
      $display("FAIL b2b_no_ovf got ovf=%b required 0", overflow);
    else n_pass++;
    for (int k = 0; k < 7; k++) begin
      exp_b = q.pop_front();
      tick();
      n_checks++;
      if (rdata !== exp_b)
        $display("FAIL b2b_drain_%0d got rdata=%h required %h", k, rdata, exp_b);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h70 + k);
      q.push_back(wdata);
      exp_b = q.pop_front();
      tick();
      n_checks++;
      if (rdata !== exp_b || count !== 4'd1)
        $display("FAIL b2b_one_%0d got rdata=%h count=%0d required %h 1", k, rdata, count, exp_b);
      else n_pass++;
    end
    wr_en = 1'b0;
    exp_b = q.pop_front();
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rdata !== exp_b || empty !== 1'b1)
      $display("FAIL b2b_last got rdata=%h empty=%b required %h 1", rdata, empty, exp_b);
    else n_pass++;
  endtask

  task automatic test_thresholds();
    n_checks++;
    if (almost_empty2 !== 1'b1 || almost_full2 !== 1'b0)
      $display("FAIL thr_c0 got ae=%b af=%b required 1 0", almost_empty2, almost_full2);
    else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      wr_en2 = 1'b1;
      wdata2 = 8'(c);
      tick();
      n_checks++;
      if (count2 !== 3'(c) || almost_empty2 !== (c <= 1) || almost_full2 !== (c >= 3) || full2 !== (c == 4))
        $display("FAIL thr_up_%0d got count=%0d ae=%b af=%b full=%b required %0d %b %b %b",
                 c, count2, almost_empty2, almost_full2, full2, c, (c <= 1), (c >= 3), (c == 4));
      else n_pass++;
    end
    wr_en2 = 1'b0;
    for (int c = 3; c >= 0; c--) begin
      rd_en2 = 1'b1;
      tick();
      n_checks++;
      if (count2 !== 3'(c) || almost_empty2 !== (c <= 1) || almost_full2 !== (c >= 3))
        $display("FAIL thr_down_%0d got count=%0d ae=%b af=%b required %0d %b %b",
                 c, count2, almost_empty2, almost_full2, c, (c <= 1), (c >= 3));
      else n_pass++;
    end
    rd_en2 = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (count !== 4'd5 || rdata !== 8'h31)
      $display("FAIL arst_pre got count=%0d rdata=%h required 5 31", count, rdata);
    else n_pass++;
    wr_en = 1'b1;
    wdata = 8'h99;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (count !== 4'd0 || rdata !== 8'h00 || rd_valid !== 1'b0 || empty !== 1'b1 ||
        full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0 || overflow !== 1'b0)
      $display("FAIL arst_now got count=%0d rdata=%h rd_valid=%b empty=%b full=%b ae=%b af=%b ovf=%b required 0 00 0 1 0 1 0 0",
               count, rdata, rd_valid, empty, full, almost_empty, almost_full, overflow);
    else n_pass++;
    wr_en = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'hE1 + i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (rdata !== 8'(8'hE1 + i) || rd_valid !== 1'b1)
        $display("FAIL arst_after_%0d got rdata=%h rd_valid=%b required %h 1", i, rdata, rd_valid, 8'(8'hE1 + i));
      else n_pass++;
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (empty !== 1'b1 || underflow !== 1'b0)
      $display("FAIL arst_end got empty=%b unf=%b required 1 0", empty, underflow);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clr      = 1'b0;
    wr_en    = 1'b0;
    wdata    = 8'h00;
    rd_en    = 1'b0;
    clr2     = 1'b0;
    wr_en2   = 1'b0;
    wdata2   = 8'h00;
    rd_en2   = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_thresholds();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_buf.md
# sync_fifo_buf

Single-clock, parametrised FIFO buffer with built-in pointer control, occupancy count, programmable almost-full/almost-empty thresholds, registered read data and sticky overflow/underflow error flags. It is the next generation of the bare FIFO storage array: it owns its own pointers and status, so it drops in directly between the UART RX/TX byte paths and the system controller wherever both sides share one clock.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_SIZE, 3, address width; depth DEPTH = 2**ADDR_SIZE (ADDR_SIZE ≥ 1)
- AF_LEVEL, 6, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush: empties FIFO, clears error flags
- wr_en  in  1  write request
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rdata  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rdata holds a newly read word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: DEPTH × DATA_WIDTH array, not reset; contents undefined until written.
- Pointers wr_ptr, rd_ptr are ADDR_SIZE+1 bits; low ADDR_SIZE bits index the array, natural wrap from DEPTH-1 to 0 with MSB toggle.
- Write accept: wr_acc = wr_en & (!full | rd_acc). Writes to full FIFO are accepted only if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & !empty. No write-to-read bypass: a read on an empty FIFO is rejected even if wr_en is high the same cycle.
- On wr_acc: mem[wr_ptr] <= wdata, wr_ptr += 1. On rd_acc: rdata <= mem[rd_ptr], rd_ptr += 1.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- wr_en & !wr_acc sets overflow; rd_en & !rd_acc sets underflow. Both hold until clr or rst.
- clr (priority over wr_en/rd_en): pointers, count → 0; overflow, underflow, rd_valid → 0; rdata holds its value. Requests in the clr cycle are ignored and flag nothing.
- rst (async, highest priority): pointers, count, rdata, rd_valid, overflow, underflow → 0. Reset mid-transfer discards all contents.

## Timing
- Reset values: rdata 0, rd_valid 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (AF_LEVEL ≥ 1), overflow 0, underflow 0.
- Read latency 1: rd_acc at edge N → rdata valid and rd_valid = 1 after edge N, for one cycle; rdata holds between reads.
- count, full, empty, almost_* reflect all accepts through the most recent edge (registered count; flags may decode count combinationally, no other input dependence).
- Written word readable from the cycle after its write edge (empty deasserts then).
- Back-to-back read and write every cycle sustained at full throughput in any occupancy state, including full and with count = 1.

## Test plan
- Reset then write 0x11..0x88 into DEPTH=8 → full=1, count=8, almost_full set at count 6; then read 8 → rdata 0x11..0x88 in order, one cycle after each rd_en, empty=1.
- Write when full (wdata 0xAA, no rd_en) → rejected, overflow=1, count stays 8, next reads unaffected; clr → count 0, overflow 0.
- rd_en while empty with simultaneous wr_en 0x5A → read rejected, underflow=1, write accepted, count 1; next-cycle read returns 0x5A.
- Full FIFO, simultaneous wr_en 0xC3 and rd_en → both accepted, count stays 8, oldest word out; after 20 cycles of streaming check pointer wrap and data order.
- Thresholds AF_LEVEL=3, AE_LEVEL=1 at ADDR_SIZE=2 → almost_empty at count 0..1, almost_full at count 3..4.
- Assert rst mid-stream at count 5 → all outputs return to reset values immediately, without a clock edge; subsequent writes start from address 0.
